// File: rtl/pattern_gen_sequencer_if.sv
// Pattern memory read port: strobe and address out, data back one cycle later.
interface pattern_gen_sequencer_if;
  logic       mem_rd_en;
  logic [7:0] mem_rd_addr;
  logic [7:0] mem_rd_data;

  modport master (output mem_rd_en, output mem_rd_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, input mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/pattern_gen_sequencer.sv
// Plays bytes from a pattern memory onto gpio_out as fixed-width slices, each
// held for a programmable period, with one-byte prefetch for gapless playback.
module pattern_gen_sequencer (
  input  logic                            clk,
  input  logic                            rst_sync,
  input  logic [7:0]                      cfg_end_address_pat_gen,
  input  logic [1:0]                      cfg_num_gpio_sel_pat_gen,
  input  logic [2:0]                      cfg_timestep_sel_pat_gen,
  input  logic [4:0]                      cfg_stage1_count_sel_pat_gen,
  input  logic                            cfg_repeat_enable_pat_gen,
  input  logic                            cfg_enable_pat_gen,
  pattern_gen_sequencer_if.master         mem,
  output logic [7:0]                      gpio_out,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_end;
  logic [1:0]  r_sel;
  logic [2:0]  r_ts;
  logic [4:0]  r_s1;
  logic        r_rep;
  logic [11:0] r_cnt;
  logic [2:0]  r_slice;
  logic [7:0]  r_byte, r_nxt, r_raddr;
  logic        r_nxt_vld, r_pend, r_more;

  logic [12:0] w_period;
  logic [11:0] w_pm1;
  logic [2:0]  w_slices_m1;
  logic        w_period_end, w_byte_end, w_have, w_run, w_consume, w_issue;
  logic [7:0]  w_new;

  function automatic logic [7:0] f_slice(input logic [7:0] b, input logic [1:0] sel,
                                         input logic [2:0] k);
    logic [2:0] amt;
    logic [7:0] msk;
    amt = 3'({2'b00, k} << sel);
    msk = 8'hFF >> (4'd8 - (4'd1 << sel));
    return (b >> amt) & msk;
  endfunction

  assign w_period     = (13'(r_s1) + 13'd1) << r_ts;
  assign w_pm1        = 12'(w_period - 13'd1);
  assign w_slices_m1  = 3'b111 >> r_sel;
  assign w_period_end = (r_cnt == w_pm1);
  assign w_byte_end   = w_period_end && (r_slice == w_slices_m1);

  // At most one byte is ever in flight or buffered: r_pend and r_nxt_vld are exclusive.
  assign w_have    = r_pend | r_nxt_vld;
  assign w_new     = r_pend ? mem.mem_rd_data : r_nxt;
  assign w_run     = cfg_enable_pat_gen && (r_state == S_FETCH || r_state == S_PLAY);
  assign w_consume = w_run && ((r_state == S_FETCH && r_pend) ||
                               (r_state == S_PLAY && w_byte_end && w_have));
  assign w_issue   = w_run && r_more && (!w_have || w_consume);

  assign mem.mem_rd_en   = w_issue;
  assign mem.mem_rd_addr = r_raddr;
  assign busy            = (r_state == S_FETCH) || (r_state == S_PLAY);
  assign done            = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cfg_enable_pat_gen) w_state_nxt = S_FETCH;
      S_FETCH: if (!cfg_enable_pat_gen) w_state_nxt = S_IDLE;
               else if (r_pend)         w_state_nxt = S_PLAY;
      S_PLAY:  if (!cfg_enable_pat_gen)       w_state_nxt = S_IDLE;
               else if (w_byte_end && !w_have) w_state_nxt = S_DONE;
      S_DONE:  if (!cfg_enable_pat_gen) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      r_end     <= '0;
      r_sel     <= '0;
      r_ts      <= '0;
      r_s1      <= '0;
      r_rep     <= 1'b0;
      r_cnt     <= '0;
      r_slice   <= '0;
      r_byte    <= '0;
      r_nxt     <= '0;
      r_raddr   <= '0;
      r_nxt_vld <= 1'b0;
      r_pend    <= 1'b0;
      r_more    <= 1'b0;
      gpio_out  <= '0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        if (r_raddr == r_end) begin
          r_raddr <= 8'd0;
          if (!r_rep) r_more <= 1'b0;
        end else begin
          r_raddr <= r_raddr + 8'd1;
        end
      end

      if (r_pend && !w_consume) begin
        r_nxt     <= mem.mem_rd_data;
        r_nxt_vld <= 1'b1;
      end else if (w_consume) begin
        r_nxt_vld <= 1'b0;
      end

      if (w_consume) begin
        r_byte   <= w_new;
        r_slice  <= 3'd0;
        r_cnt    <= 12'd0;
        gpio_out <= f_slice(w_new, r_sel, 3'd0);
      end else if (r_state == S_PLAY && w_period_end) begin
        r_cnt    <= 12'd0;
        r_slice  <= r_slice + 3'd1;
        gpio_out <= f_slice(r_byte, r_sel, r_slice + 3'd1);
      end else if (r_state == S_PLAY) begin
        r_cnt <= r_cnt + 12'd1;
      end

      if (r_state == S_IDLE && cfg_enable_pat_gen) begin
        r_end   <= cfg_end_address_pat_gen;
        r_sel   <= cfg_num_gpio_sel_pat_gen;
        r_ts    <= cfg_timestep_sel_pat_gen;
        r_s1    <= cfg_stage1_count_sel_pat_gen;
        r_rep   <= cfg_repeat_enable_pat_gen;
        r_more  <= 1'b1;
        r_raddr <= 8'd0;
      end

      // Leaving the run (abort or finish) drops output, counters and any read in flight.
      if (w_state_nxt == S_IDLE || w_state_nxt == S_DONE) begin
        gpio_out  <= '0;
        r_cnt     <= '0;
        r_slice   <= '0;
        r_pend    <= 1'b0;
        r_nxt_vld <= 1'b0;
        r_more    <= 1'b0;
        r_raddr   <= '0;
      end
    end
  end

endmodule

// File: doc/pattern_gen_sequencer.md
PATTERN_GEN_SEQUENCER -- requirements
Module: pattern_gen_sequencer

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all flops rise on posedge.
REQ-002 SHALL have: rst_sync  in  1  reset, asynchronous and active-high.
REQ-003 SHALL have: cfg_end_address_pat_gen  in  8  last pattern memory address, inclusive.
REQ-004 SHALL have: cfg_num_gpio_sel_pat_gen  in  2  slice width: 0=1 gpio, 1=2, 2=4, 3=8.
REQ-005 SHALL have: cfg_timestep_sel_pat_gen  in  3  period shift.
REQ-006 SHALL have: cfg_stage1_count_sel_pat_gen  in  5  period base.
REQ-007 SHALL have: cfg_repeat_enable_pat_gen  in  1  wrap to address 0 after end.
REQ-008 SHALL have: cfg_enable_pat_gen  in  1  level run request.
REQ-009 SHALL have: mem_rd_en  out  1  pattern memory read strobe.
REQ-010 SHALL have: mem_rd_addr  out  8  pattern memory read address.
REQ-011 SHALL have: mem_rd_data  in  8  read data, valid the cycle after mem_rd_en.
REQ-012 SHALL have: gpio_out  out  8  pattern output, registered.
REQ-013 SHALL have: busy  out  1  high in FETCH or PLAY.
REQ-014 SHALL have: done  out  1  high in DONE.

Function
REQ-015 SHALL implement states IDLE, FETCH, PLAY, DONE.
REQ-016 Slice period SHALL be P = (stage1+1) << timestep clocks (range 1..4096); counter width 12 bits.
REQ-017 Slices per byte SHALL be 8,4,2,1 for sel 0..3; slice k SHALL drive byte bits [W*k+W-1 : W*k] onto gpio_out[W-1:0] (W = slice width); unused gpio_out bits SHALL be 0.
REQ-018 IDLE->FETCH at the edge where cfg_enable is sampled high (E0); all cfg fields SHALL be latched at E0 and changes ignored until the next return to IDLE.
REQ-019 In the cycle after E0: mem_rd_en=1, mem_rd_addr=0; slice 0 of byte 0 SHALL appear on gpio_out from edge E2 (FETCH->PLAY).
REQ-020 Each slice SHALL last exactly P clocks.
REQ-021 Bytes SHALL play gaplessly in every configuration, including P=1 with sel=3; the next byte SHALL be prefetched, and at most one read SHALL be issued per byte.
REQ-022 Address SHALL increment after each byte.
REQ-023 After byte end_address: with repeat=1, SHALL continue at address 0 with no gap; with repeat=0, SHALL enter DONE when the last slice's P clocks expire.
REQ-024 end_address=0 SHALL play a single byte; end_address=255 SHALL play all 256 bytes; the 8-bit address wrap 255->0 SHALL occur only via repeat.
REQ-025 No read SHALL be issued beyond end_address when repeat=0.
REQ-026 gpio_out SHALL be 0 in IDLE and DONE.
REQ-027 DONE->IDLE when cfg_enable is sampled low.
REQ-028 cfg_enable low in FETCH or PLAY: next state SHALL be IDLE; gpio_out=0, counters cleared, any returning read data discarded.
REQ-029 cfg_enable toggling low then high SHALL restart from address 0.
REQ-030 mem_rd_en SHALL be 0 outside FETCH/PLAY.

Reset
REQ-031 rst_sync high SHALL immediately force: state IDLE; gpio_out=0; mem_rd_en=0; mem_rd_addr=0; busy=0; done=0; all counters and latched cfg = 0.
REQ-032 Reset asserted mid-PLAY SHALL take effect without waiting for a clock.
REQ-033 After reset release, no activity SHALL occur until cfg_enable is sampled high.

Verification
REQ-034 sel=3, stage1=0, ts=0, end=1, repeat=0, mem={A5,3C}; enable -> gpio_out A5 at E2 for 1 clk, 3C for 1 clk, then 00, done=1, busy=0.
REQ-035 sel=0, stage1=2, ts=1 (P=6), end=0, mem[0]=81 -> gpio_out[0]: 1 for 6 clks, 0 for 36 clks, 1 for 6 clks; then DONE.
REQ-036 sel=1, P=1, end=2, repeat=1, mem={E4,1B,00} -> repeating 2-bit sequence 0,1,2,3,3,2,1,0,0,0,0,0 with no gap at the wrap; exactly one read per byte.
REQ-037 enable dropped mid-PLAY of byte 3 -> gpio_out=0 next edge; re-enable -> restart at addr 0, E2 latency.
REQ-038 rst_sync pulsed mid-PLAY with stage1=31, ts=7 (P=4096) -> all outputs immediately at reset values; first slice after release lasts 4096 clks.
REQ-039 cfg fields rewritten during PLAY -> output timing and data unchanged until restart.
